// File: rtl/branch_pkg.sv
// Shared types and helpers for the branch resolve unit: buffer entry layout,
// PC step and the 2-bit saturating PHT counter update.
package branch_pkg;

    localparam int PC_W  = 32;
    localparam int IDX_W = 8;

    localparam logic [PC_W-1:0] PC_STEP = 32'd4;

    typedef struct packed {
        logic [PC_W-1:0]  pc;
        logic [PC_W-1:0]  predPC;
        logic [IDX_W-1:0] ghrIndex;
        logic [1:0]       phtState;
        logic             predTaken;
        logic             isJAL;
        logic             valid;
        logic             done;
    } bru_entry_t;

    function automatic logic [1:0] sat_update(input logic [1:0] state, input logic taken);
        if (taken) begin
            return (state == 2'b11) ? 2'b11 : state + 2'b01;
        end
        return (state == 2'b00) ? 2'b00 : state - 2'b01;
    endfunction

endpackage

// File: rtl/bru_queue.sv
// Circular, in-order buffer of in-flight control instructions with a tag read
// port, done marking, in-order retirement and flush of entries younger than a tag.
module bru_queue
    import branch_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  bru_entry_t               push_entry_i,
    input  logic [$clog2(DEPTH)-1:0] rd_tag_i,
    output bru_entry_t               rd_entry_o,
    input  logic                     done_i,
    input  logic                     flush_i,
    output logic                     ready_o,
    output logic [$clog2(DEPTH)-1:0] tail_o
);

    localparam int PTR = $clog2(DEPTH);

    bru_entry_t           payload_q [DEPTH];
    logic [DEPTH-1:0]     valid_q, valid_d;
    logic [DEPTH-1:0]     done_q, done_d;
    logic [PTR-1:0]       head_q, head_d;
    logic [PTR-1:0]       tail_q, tail_d;
    logic [PTR:0]         count_q, count_d;

    logic                 push_ok;
    logic                 pop;
    logic [PTR-1:0]       res_off;
    logic [PTR-1:0]       off;
    logic [PTR-1:0]       diff;

    assign ready_o = (count_q != (PTR+1)'(DEPTH));
    assign tail_o  = tail_q;
    assign push_ok = push_i && ready_o && !flush_i;
    assign pop     = (count_q != '0) && valid_q[head_q] && done_q[head_q];

    always_comb begin
        rd_entry_o       = payload_q[rd_tag_i];
        rd_entry_o.valid = valid_q[rd_tag_i];
        rd_entry_o.done  = done_q[rd_tag_i];
    end

    always_comb begin
        valid_d = valid_q;
        done_d  = done_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        res_off = rd_tag_i - head_q;
        off     = '0;
        diff    = '0;

        if (pop) begin
            valid_d[head_q] = 1'b0;
            done_d[head_q]  = 1'b0;
            head_d          = head_q + 1'b1;
        end

        if (done_i) begin
            done_d[rd_tag_i] = 1'b1;
        end

        if (flush_i) begin
            // Age is the distance from head; anything older-than-or-equal survives.
            for (int i = 0; i < DEPTH; i++) begin
                off = PTR'(i) - head_q;
                if (off > res_off) begin
                    valid_d[i] = 1'b0;
                    done_d[i]  = 1'b0;
                end
            end
            tail_d  = rd_tag_i + 1'b1;
            diff    = tail_d - head_d;
            // The resolved entry survives, so a zero distance means a full ring.
            count_d = (diff == '0) ? (PTR+1)'(DEPTH) : {1'b0, diff};
        end else begin
            if (push_ok) begin
                valid_d[tail_q] = 1'b1;
                done_d[tail_q]  = 1'b0;
                tail_d          = tail_q + 1'b1;
            end
            count_d = count_q + (PTR+1)'(push_ok) - (PTR+1)'(pop);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
            done_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            done_q  <= done_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            payload_q[tail_q] <= push_entry_i;
        end
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Records fetch-time prediction metadata per control instruction, checks
// out-of-order resolutions against it and drives registered fetch corrections.
module branch_resolve_unit
    import branch_pkg::*;
#(
    parameter int WIDTH = 31,
    parameter int INDEX = 7,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     resetN,
    input  logic                     enqValid,
    input  logic [WIDTH:0]           enqPC,
    input  logic [WIDTH:0]           enqPredPC,
    input  logic [INDEX:0]           enqGHRIndex,
    input  logic [1:0]               enqPHTState,
    input  logic                     enqRedirect,
    input  logic                     enqJAL,
    output logic                     enqReady,
    output logic [$clog2(DEPTH)-1:0] enqTag,
    input  logic                     resValid,
    input  logic [$clog2(DEPTH)-1:0] resTag,
    input  logic                     resTaken,
    input  logic [WIDTH:0]           resTarget,
    output logic                     freeze,
    output logic                     mispredict,
    output logic                     misdirect,
    output logic [WIDTH:0]           validAddress,
    output logic [WIDTH:0]           target,
    output logic [WIDTH:0]           oldPC,
    output logic                     isJAL,
    output logic                     isControl,
    output logic                     takenBranch,
    output logic                     branch,
    output logic                     writeBTB,
    output logic [INDEX:0]           updateIndex,
    output logic [1:0]               newState
);

    bru_entry_t push_entry;
    bru_entry_t rd_entry;
    logic       accept;
    logic       dir_wrong;
    logic       tgt_wrong;
    logic       flush;

    logic             mispredict_q, mispredict_d;
    logic             misdirect_q, misdirect_d;
    logic [WIDTH:0]   validAddress_q, validAddress_d;
    logic [WIDTH:0]   target_q, target_d;
    logic [WIDTH:0]   oldPC_q, oldPC_d;
    logic             isJAL_q, isJAL_d;
    logic             isControl_q, isControl_d;
    logic             takenBranch_q, takenBranch_d;
    logic             branch_q, branch_d;
    logic             writeBTB_q, writeBTB_d;
    logic [INDEX:0]   updateIndex_q, updateIndex_d;
    logic [1:0]       newState_q, newState_d;

    always_comb begin
        push_entry           = '0;
        push_entry.pc        = enqPC;
        push_entry.predPC    = enqPredPC;
        push_entry.ghrIndex  = enqGHRIndex;
        push_entry.phtState  = enqPHTState;
        push_entry.predTaken = enqRedirect;
        push_entry.isJAL     = enqJAL;
        push_entry.valid     = 1'b1;
    end

    // Stale or repeated resolutions (flushed, retired or already done) are dropped here.
    assign accept    = resValid && rd_entry.valid && !rd_entry.done;
    assign dir_wrong = resTaken != rd_entry.predTaken;
    assign tgt_wrong = resTaken && rd_entry.predTaken && (resTarget != rd_entry.predPC);
    assign flush     = accept && (dir_wrong || tgt_wrong);

    bru_queue #(
        .DEPTH(DEPTH)
    ) u_queue (
        .clk_i       (clk),
        .rst_ni      (resetN),
        .push_i      (enqValid),
        .push_entry_i(push_entry),
        .rd_tag_i    (resTag),
        .rd_entry_o  (rd_entry),
        .done_i      (accept),
        .flush_i     (flush),
        .ready_o     (enqReady),
        .tail_o      (enqTag)
    );

    assign freeze = ~enqReady;

    always_comb begin
        mispredict_d   = 1'b0;
        misdirect_d    = 1'b0;
        validAddress_d = '0;
        target_d       = '0;
        oldPC_d        = '0;
        isJAL_d        = 1'b0;
        isControl_d    = 1'b0;
        takenBranch_d  = 1'b0;
        branch_d       = 1'b0;
        writeBTB_d     = 1'b0;
        updateIndex_d  = '0;
        newState_d     = '0;
        if (accept) begin
            mispredict_d   = dir_wrong;
            misdirect_d    = tgt_wrong;
            validAddress_d = resTaken ? resTarget : (rd_entry.pc + PC_STEP);
            target_d       = resTarget;
            oldPC_d        = rd_entry.pc;
            isJAL_d        = rd_entry.isJAL;
            isControl_d    = 1'b1;
            takenBranch_d  = resTaken;
            branch_d       = ~rd_entry.isJAL;
            writeBTB_d     = resTaken;
            updateIndex_d  = rd_entry.ghrIndex;
            newState_d     = sat_update(rd_entry.phtState, resTaken);
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            mispredict_q   <= 1'b0;
            misdirect_q    <= 1'b0;
            validAddress_q <= '0;
            target_q       <= '0;
            oldPC_q        <= '0;
            isJAL_q        <= 1'b0;
            isControl_q    <= 1'b0;
            takenBranch_q  <= 1'b0;
            branch_q       <= 1'b0;
            writeBTB_q     <= 1'b0;
            updateIndex_q  <= '0;
            newState_q     <= '0;
        end else begin
            mispredict_q   <= mispredict_d;
            misdirect_q    <= misdirect_d;
            validAddress_q <= validAddress_d;
            target_q       <= target_d;
            oldPC_q        <= oldPC_d;
            isJAL_q        <= isJAL_d;
            isControl_q    <= isControl_d;
            takenBranch_q  <= takenBranch_d;
            branch_q       <= branch_d;
            writeBTB_q     <= writeBTB_d;
            updateIndex_q  <= updateIndex_d;
            newState_q     <= newState_d;
        end
    end

    assign mispredict   = mispredict_q;
    assign misdirect    = misdirect_q;
    assign validAddress = validAddress_q;
    assign target       = target_q;
    assign oldPC        = oldPC_q;
    assign isJAL        = isJAL_q;
    assign isControl    = isControl_q;
    assign takenBranch  = takenBranch_q;
    assign branch       = branch_q;
    assign writeBTB     = writeBTB_q;
    assign updateIndex  = updateIndex_q;
    assign newState     = newState_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: enqueue/resolve scenarios with
// hand-computed expected outputs, flush, full buffer, out-of-order retire, reset.
module tb_branch_resolve_unit;

    logic        clk = 1'b0;
    logic        resetN;
    logic        enqValid;
    logic [31:0] enqPC, enqPredPC;
    logic [7:0]  enqGHRIndex;
    logic [1:0]  enqPHTState;
    logic        enqRedirect, enqJAL;
    logic        enqReady;
    logic [2:0]  enqTag;
    logic        resValid;
    logic [2:0]  resTag;
    logic        resTaken;
    logic [31:0] resTarget;
    logic        freeze, mispredict, misdirect;
    logic [31:0] validAddress, target, oldPC;
    logic        isJAL, isControl, takenBranch, branch, writeBTB;
    logic [7:0]  updateIndex;
    logic [1:0]  newState;

    int checks = 0;
    int fails  = 0;
    logic [2:0] tag;

    branch_resolve_unit dut (
        .clk(clk), .resetN(resetN),
        .enqValid(enqValid), .enqPC(enqPC), .enqPredPC(enqPredPC),
        .enqGHRIndex(enqGHRIndex), .enqPHTState(enqPHTState),
        .enqRedirect(enqRedirect), .enqJAL(enqJAL),
        .enqReady(enqReady), .enqTag(enqTag),
        .resValid(resValid), .resTag(resTag), .resTaken(resTaken), .resTarget(resTarget),
        .freeze(freeze), .mispredict(mispredict), .misdirect(misdirect),
        .validAddress(validAddress), .target(target), .oldPC(oldPC),
        .isJAL(isJAL), .isControl(isControl), .takenBranch(takenBranch),
        .branch(branch), .writeBTB(writeBTB), .updateIndex(updateIndex), .newState(newState)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running required finished");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetN = 1'b0; enqValid = 1'b0; resValid = 1'b0;
        enqPC = '0; enqPredPC = '0; enqGHRIndex = '0; enqPHTState = '0;
        enqRedirect = 1'b0; enqJAL = 1'b0; resTag = '0; resTaken = 1'b0; resTarget = '0;
        tick();
        tick();
        resetN = 1'b1;
    endtask

    task automatic enq(input logic [31:0] pc, input logic [31:0] ppc, input logic [7:0] idx,
                       input logic [1:0] st, input logic redir, input logic jal,
                       output logic [2:0] t);
        enqValid = 1'b1; enqPC = pc; enqPredPC = ppc; enqGHRIndex = idx;
        enqPHTState = st; enqRedirect = redir; enqJAL = jal;
        t = enqTag;
        tick();
        enqValid = 1'b0;
    endtask

    task automatic resolve(input logic [2:0] t, input logic tk, input logic [31:0] tgt);
        resValid = 1'b1; resTag = t; resTaken = tk; resTarget = tgt;
        tick();
        resValid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        resetN = 1'b0;
        tick();
        checks++; if ({mispredict, misdirect, validAddress, target, oldPC, isJAL, isControl, takenBranch, branch, writeBTB, updateIndex, newState} !== '0) begin fails++; $display("FAIL reset_outputs: got nonzero required 0"); end
        checks++; if (enqReady !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b required 1", enqReady); end
        checks++; if (freeze !== 1'b0) begin fails++; $display("FAIL reset_freeze: got %b required 0", freeze); end
        checks++; if (enqTag !== 3'd0) begin fails++; $display("FAIL reset_tag: got %0d required 0", enqTag); end
        resetN = 1'b1;
    endtask

    task automatic test_not_taken();
        do_reset();
        enq(32'h100, 32'h500, 8'h3A, 2'b01, 1'b0, 1'b0, tag);
        checks++; if (tag !== 3'd0) begin fails++; $display("FAIL nt_tag: got %0d required 0", tag); end
        resolve(3'd0, 1'b0, 32'h180);
        checks++; if (mispredict !== 1'b0) begin fails++; $display("FAIL nt_mispredict: got %b required 0", mispredict); end
        checks++; if (misdirect !== 1'b0) begin fails++; $display("FAIL nt_misdirect: got %b required 0", misdirect); end
        checks++; if (validAddress !== 32'h104) begin fails++; $display("FAIL nt_validAddress: got %h required 104", validAddress); end
        checks++; if (newState !== 2'd0) begin fails++; $display("FAIL nt_newState: got %0d required 0", newState); end
        checks++; if (updateIndex !== 8'h3A) begin fails++; $display("FAIL nt_updateIndex: got %h required 3a", updateIndex); end
        checks++; if ({isControl, branch, isJAL, takenBranch, writeBTB} !== 5'b11000) begin fails++; $display("FAIL nt_flags: got %b required 11000", {isControl, branch, isJAL, takenBranch, writeBTB}); end
        checks++; if (oldPC !== 32'h100 || target !== 32'h180) begin fails++; $display("FAIL nt_pc_target: got %h/%h required 100/180", oldPC, target); end
        checks++; if (dut.u_queue.head_q !== 3'd0) begin fails++; $display("FAIL nt_head_before: got %0d required 0", dut.u_queue.head_q); end
        tick();
        checks++; if (dut.u_queue.head_q !== 3'd1) begin fails++; $display("FAIL nt_retire: got head %0d required 1", dut.u_queue.head_q); end
        checks++; if (isControl !== 1'b0) begin fails++; $display("FAIL nt_pulse_width: got %b required 0", isControl); end
    endtask

    task automatic test_misdirect();
        enq(32'h200, 32'h300, 8'h11, 2'b10, 1'b1, 1'b0, tag);
        checks++; if (tag !== 3'd1) begin fails++; $display("FAIL md_tag: got %0d required 1", tag); end
        resolve(tag, 1'b1, 32'h340);
        checks++; if (misdirect !== 1'b1) begin fails++; $display("FAIL md_misdirect: got %b required 1", misdirect); end
        checks++; if (mispredict !== 1'b0) begin fails++; $display("FAIL md_mispredict: got %b required 0", mispredict); end
        checks++; if (validAddress !== 32'h340) begin fails++; $display("FAIL md_validAddress: got %h required 340", validAddress); end
        checks++; if ({writeBTB, takenBranch} !== 2'b11) begin fails++; $display("FAIL md_writeBTB: got %b required 11", {writeBTB, takenBranch}); end
        checks++; if (newState !== 2'd3) begin fails++; $display("FAIL md_newState: got %0d required 3", newState); end
        tick();
        checks++; if (misdirect !== 1'b0) begin fails++; $display("FAIL md_pulse_width: got %b required 0", misdirect); end
    endtask

    task automatic test_flush();
        do_reset();
        for (int i = 0; i < 4; i++) enq(32'h1000 + 32'(i) * 4, 32'h0, 8'(i), 2'b01, 1'b0, 1'b0, tag);
        resolve(3'd1, 1'b1, 32'h2000);
        checks++; if (mispredict !== 1'b1) begin fails++; $display("FAIL fl_mispredict: got %b required 1", mispredict); end
        checks++; if (validAddress !== 32'h2000) begin fails++; $display("FAIL fl_validAddress: got %h required 2000", validAddress); end
        checks++; if (enqTag !== 3'd2) begin fails++; $display("FAIL fl_tail: got %0d required 2", enqTag); end
        resolve(3'd3, 1'b0, 32'h0);
        checks++; if ({isControl, mispredict, misdirect} !== 3'b000) begin fails++; $display("FAIL fl_stale_resolve: got %b required 000", {isControl, mispredict, misdirect}); end
        enq(32'h3000, 32'h0, 8'h0, 2'b00, 1'b0, 1'b0, tag);
        checks++; if (tag !== 3'd2) begin fails++; $display("FAIL fl_next_tag: got %0d required 2", tag); end
        checks++; if (enqTag !== 3'd3) begin fails++; $display("FAIL fl_tail_after: got %0d required 3", enqTag); end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < 8; i++) enq(32'h400 + 32'(i) * 4, 32'h0, 8'h0, 2'b01, 1'b0, 1'b0, tag);
        checks++; if (tag !== 3'd7) begin fails++; $display("FAIL full_last_tag: got %0d required 7", tag); end
        checks++; if ({enqReady, freeze} !== 2'b01) begin fails++; $display("FAIL full_flags: got %b required 01", {enqReady, freeze}); end
        enq(32'hDEAD, 32'h0, 8'h0, 2'b00, 1'b0, 1'b0, tag);
        checks++; if ({enqReady, enqTag} !== {1'b0, 3'd0}) begin fails++; $display("FAIL full_ignored: got ready %b tag %0d required 0/0", enqReady, enqTag); end
        resolve(3'd0, 1'b0, 32'h0);
        checks++; if (oldPC !== 32'h400) begin fails++; $display("FAIL full_resolve_pc: got %h required 400", oldPC); end
        checks++; if (enqReady !== 1'b0) begin fails++; $display("FAIL full_ready_early: got %b required 0", enqReady); end
        tick();
        checks++; if ({enqReady, freeze} !== 2'b10) begin fails++; $display("FAIL full_ready_after: got %b required 10", {enqReady, freeze}); end
    endtask

    task automatic test_out_of_order();
        do_reset();
        for (int i = 0; i < 3; i++) enq(32'h600 + 32'(i) * 16, 32'h0, 8'h0, 2'b01, 1'b0, 1'b0, tag);
        resolve(3'd2, 1'b0, 32'h0);
        checks++; if ({isControl, oldPC} !== {1'b1, 32'h620}) begin fails++; $display("FAIL ooo_pulse2: got %b/%h required 1/620", isControl, oldPC); end
        tick();
        checks++; if ({isControl, dut.u_queue.head_q} !== {1'b0, 3'd0}) begin fails++; $display("FAIL ooo_hold: got %b/%0d required 0/0", isControl, dut.u_queue.head_q); end
        resolve(3'd0, 1'b0, 32'h0);
        checks++; if ({isControl, oldPC} !== {1'b1, 32'h600}) begin fails++; $display("FAIL ooo_pulse0: got %b/%h required 1/600", isControl, oldPC); end
        tick();
        checks++; if ({isControl, dut.u_queue.head_q} !== {1'b0, 3'd1}) begin fails++; $display("FAIL ooo_head1: got %b/%0d required 0/1", isControl, dut.u_queue.head_q); end
        resolve(3'd1, 1'b0, 32'h0);
        checks++; if ({isControl, oldPC} !== {1'b1, 32'h610}) begin fails++; $display("FAIL ooo_pulse1: got %b/%h required 1/610", isControl, oldPC); end
        tick();
        tick();
        checks++; if ({isControl, dut.u_queue.head_q} !== {1'b0, 3'd3}) begin fails++; $display("FAIL ooo_head3: got %b/%0d required 0/3", isControl, dut.u_queue.head_q); end
    endtask

    task automatic test_saturation_and_reset();
        do_reset();
        enq(32'h700, 32'h800, 8'h05, 2'b11, 1'b1, 1'b1, tag);
        resolve(tag, 1'b1, 32'h800);
        checks++; if (newState !== 2'd3) begin fails++; $display("FAIL sat_high: got %0d required 3", newState); end
        checks++; if ({mispredict, misdirect, isJAL, branch} !== 4'b0010) begin fails++; $display("FAIL sat_jal_flags: got %b required 0010", {mispredict, misdirect, isJAL, branch}); end
        tick();
        enq(32'h900, 32'h0, 8'h06, 2'b00, 1'b0, 1'b0, tag);
        resolve(tag, 1'b0, 32'h0);
        checks++; if (newState !== 2'd0 || validAddress !== 32'h904) begin fails++; $display("FAIL sat_low: got %0d/%h required 0/904", newState, validAddress); end
        tick();
        enq(32'hA00, 32'h0, 8'h07, 2'b01, 1'b0, 1'b0, tag);
        resolve(tag, 1'b1, 32'hB00);
        checks++; if ({mispredict, isControl} !== 2'b11) begin fails++; $display("FAIL rst_pulse_live: got %b required 11", {mispredict, isControl}); end
        #1 resetN = 1'b0;
        #1;
        checks++; if ({mispredict, misdirect, validAddress, target, oldPC, isJAL, isControl, takenBranch, branch, writeBTB, updateIndex, newState} !== '0) begin fails++; $display("FAIL rst_midpulse: got nonzero required 0"); end
        checks++; if ({enqReady, enqTag} !== {1'b1, 3'd0}) begin fails++; $display("FAIL rst_midpulse_queue: got %b/%0d required 1/0", enqReady, enqTag); end
        resetN = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_not_taken();
        test_misdirect();
        test_flush();
        test_full();
        test_out_of_order();
        test_saturation_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
